// File: rtl/mdc_stage_ctrl.sv
// Sequencing controller for one radix-2 MDC FFT stage: counts two-lane beats and
// drives delay-line shift, commutator select, butterfly mode, twiddle address and drain.
module mdc_stage_ctrl #(
  parameter  int N     = 32,
  parameter  int DELAY = 8,
  localparam int CNT_W = $clog2(N/2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             flush,
  input  logic             bypass_cfg,
  output logic             shift_en,
  output logic             comm_sel,
  output logic             butter_mode,
  output logic [CNT_W-2:0] tw_addr,
  output logic             tw_en,
  output logic             out_valid,
  output logic             frame_done,
  output logic             busy,
  output logic             err
);

  localparam int LD = $clog2(DELAY);
  localparam int SH = $clog2(N/(4*DELAY));
  localparam int FW = $clog2(DELAY+1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t           state;
  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic [FW-1:0]    fill_cnt, flush_cnt, drain_tgt;
  logic             flush_q;
  logic             shift_beat, out_beat;
  logic [CNT_W-2:0] tw_nxt;

  // In FLUSH every cycle up to the drain target is a beat; input is ignored there.
  always_comb begin
    shift_beat = (state == FLUSH) ? (flush_cnt < drain_tgt) : in_valid;
    out_beat   = shift_beat && (fill_cnt == FW'(DELAY));
    tw_nxt     = (CNT_W-1)'((int'(out_cnt) & (DELAY-1)) << SH);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      fill_cnt    <= '0;
      flush_cnt   <= '0;
      drain_tgt   <= '0;
      flush_q     <= 1'b0;
      shift_en    <= 1'b0;
      comm_sel    <= 1'b0;
      butter_mode <= 1'b0;
      tw_addr     <= '0;
      tw_en       <= 1'b0;
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      flush_q    <= flush;
      shift_en   <= shift_beat;
      comm_sel   <= shift_beat & in_cnt[LD];
      out_valid  <= out_beat;
      tw_en      <= out_beat & out_cnt[LD];
      frame_done <= out_beat && (out_cnt == CNT_W'(N/2-1));
      if (shift_beat) tw_addr <= tw_nxt;

      // Mode only changes on a frame boundary so a frame is never split.
      if ((shift_beat && in_cnt == '0) || state == IDLE) butter_mode <= bypass_cfg;

      if (state == FLUSH && (in_valid || (flush_q && !flush))) err <= 1'b1;

      if (shift_beat) begin
        in_cnt <= in_cnt + 1'b1;
        if (fill_cnt != FW'(DELAY)) fill_cnt <= fill_cnt + 1'b1;
      end
      if (out_beat) out_cnt <= out_cnt + 1'b1;

      case (state)
        IDLE:
          if (in_valid) state <= (DELAY == 1) ? RUN : FILL;
        FILL:
          if (in_valid) begin
            if (fill_cnt == FW'(DELAY-1)) state <= RUN;
          end else if (flush) begin
            state     <= FLUSH;
            drain_tgt <= fill_cnt;
            flush_cnt <= '0;
          end
        RUN:
          if (!in_valid && flush) begin
            state     <= FLUSH;
            drain_tgt <= FW'(DELAY);
            flush_cnt <= '0;
          end
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == drain_tgt - 1'b1) begin
            state    <= IDLE;
            in_cnt   <= '0;
            out_cnt  <= '0;
            fill_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
